fp_mul_arbiter: RTL and testbench

//  Shares one fp32 multiplier (3-stage pipeline, no input valid, no stall) among NUM_REQ requesters.

---
 rtl/fp_mul_arbiter_pkg.sv | 13 +
 rtl/fp_mul_arbiter_if.sv | 30 +++
 rtl/fp_mul_arbiter_rr.sv | 37 +++
 rtl/fp_mul_arbiter.sv | 107 ++++++++++
 tb/tb_fp_mul_arbiter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/fp_mul_arbiter_pkg.sv
// Shared fp32 unit parameters and the multiplier tag type.
package parameters;

   localparam int unsigned DATA_WIDTH     = 32;
   localparam int unsigned FP_MUL_LATENCY = 3;
   localparam int unsigned DEF_NUM_REQ    = 4;

   typedef struct packed {
      logic                           v;
      logic [$clog2(DEF_NUM_REQ)-1:0] idx;
   } mul_tag_t;

endpackage

// File: rtl/fp_mul_arbiter_if.sv
// Requester and multiplier-side signals of the shared fp32 multiplier arbiter.
interface fp_mul_arbiter_if
   import parameters::*;
#(
   parameter int unsigned NUM_REQ = 4
);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic [DATA_WIDTH-1:0]         rsp_result;
   logic [DATA_WIDTH-1:0]         mul_a;
   logic [DATA_WIDTH-1:0]         mul_b;
   logic [DATA_WIDTH-1:0]         mul_result;

   // Requesters plus the multiplier instance.
   modport master (
      output req_valid, req_a, req_b, mul_result,
      input  req_ready, rsp_valid, rsp_result, mul_a, mul_b
   );

   // The arbiter.
   modport slave (
      input  req_valid, req_a, req_b, mul_result,
      output req_ready, rsp_valid, rsp_result, mul_a, mul_b
   );

endinterface

// File: rtl/fp_mul_arbiter_rr.sv
// Combinational N-way round-robin picker with its rotating priority pointer.
module rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] gidx,
   output logic                 any
);

   localparam int unsigned PW = $clog2(N);

   logic [PW-1:0] ptr;

   // Pick the first requesting index at or above ptr, wrapping modulo N.
   always_comb begin
      grant = '0;
      gidx  = '0;
      any   = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         if (!any && req[PW'((32'(ptr) + k) % N)]) begin
            any  = 1'b1;
            gidx = PW'((32'(ptr) + k) % N);
         end
      end
      if (any) grant[gidx] = 1'b1;
   end

   // Move priority just past the winner; hold when nothing is granted.
   always_ff @(posedge clk) begin
      if (rst)      ptr <= '0;
      else if (any) ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
   end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one pipelined fp32 multiplier among NUM_REQ requesters and routes results back.
module fp_mul_arbiter
   import parameters::*;
#(
   parameter int unsigned NUM_REQ         = 4,
   parameter int unsigned MUL_LATENCY     = FP_MUL_LATENCY,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              drain,
   output logic              busy,
   fp_mul_arbiter_if.slave   bus
);

   localparam int unsigned IW = $clog2(NUM_REQ);
   localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

   typedef struct packed {
      logic          v;
      logic [IW-1:0] idx;
   } tag_t;

   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] grant;
   logic [IW-1:0]      gidx;
   logic               accept;
   logic               in_flight;
   logic [CW-1:0]      cnt [NUM_REQ];
   tag_t               tag_pipe [MUL_LATENCY];

   // A requester competes only while valid, under its outstanding limit, and not draining.
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         elig[i] = bus.req_valid[i] && (cnt[i] < CW'(MAX_OUTSTANDING)) && !drain && !rst;
      end
   end

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .clk   (clk),
      .rst   (rst),
      .req   (elig),
      .grant (grant),
      .gidx  (gidx),
      .any   (accept)
   );

   assign bus.req_ready = grant;

   // Steer the granted operand pair to the multiplier; zeros form a bubble otherwise.
   always_comb begin
      bus.mul_a = '0;
      bus.mul_b = '0;
      if (accept) begin
         bus.mul_a = bus.req_a[gidx*DATA_WIDTH +: DATA_WIDTH];
         bus.mul_b = bus.req_b[gidx*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Tag pipe shadows the multiplier so the last entry lines up with mul_result.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < MUL_LATENCY; k++) tag_pipe[k] <= '0;
      end else begin
         tag_pipe[0] <= '{v: accept, idx: gidx};
         for (int unsigned k = 1; k < MUL_LATENCY; k++) tag_pipe[k] <= tag_pipe[k-1];
      end
   end

   // Register the product towards its owner; rsp_result holds between responses.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.rsp_valid  <= '0;
         bus.rsp_result <= '0;
      end else if (tag_pipe[MUL_LATENCY-1].v) begin
         bus.rsp_valid  <= NUM_REQ'(1) << tag_pipe[MUL_LATENCY-1].idx;
         bus.rsp_result <= bus.mul_result;
      end else begin
         bus.rsp_valid  <= '0;
      end
   end

   // Per-requester outstanding count: up on accept, down on response, both cancel.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (rst)
            cnt[i] <= '0;
         else if (accept && gidx == IW'(i) && !bus.rsp_valid[i])
            cnt[i] <= cnt[i] + CW'(1);
         else if (!(accept && gidx == IW'(i)) && bus.rsp_valid[i])
            cnt[i] <= cnt[i] - CW'(1);
      end
   end

   // Any valid tag in the pipe means a response is still on its way.
   always_comb begin
      in_flight = 1'b0;
      for (int unsigned k = 0; k < MUL_LATENCY; k++) in_flight = in_flight | tag_pipe[k].v;
   end

   // busy is registered from the next-state view: a new accept or a tag about to reach rsp_valid.
   always_ff @(posedge clk) begin
      if (rst) busy <= 1'b0;
      else     busy <= accept | in_flight;
   end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a 3-deep lookup multiplier model on mul_*.
module tb_fp_mul_arbiter;
   import parameters::*;

   localparam int unsigned NR = 4;

   logic clk = 1'b0;
   logic rst;
   logic drain;
   logic busy;

   fp_mul_arbiter_if #(.NUM_REQ(NR)) bus ();

   fp_mul_arbiter #(.NUM_REQ(NR), .MUL_LATENCY(3), .MAX_OUTSTANDING(2)) dut (
      .clk   (clk),
      .rst   (rst),
      .drain (drain),
      .busy  (busy),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Stand-in multiplier: known operand pairs only, three register stages.
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h3F800000 && b == 32'h3F800000) return 32'h3F800000;
      if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
      if (a == 32'h3FC00000 && b == 32'h3FC00000) return 32'h40100000;
      if (a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
      return 32'h00000000;
   endfunction

   logic [31:0] m1, m2, m3;
   always @(posedge clk) begin
      m1 <= fmul(bus.mul_a, bus.mul_b);
      m2 <= m1;
      m3 <= m2;
   end
   assign bus.mul_result = m3;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   logic [31:0] opa [NR];
   logic [31:0] opb [NR];
   logic [31:0] prd [NR];

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.req_valid = '0;
      drain = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic put(input int unsigned i);
      bus.req_a[i*32 +: 32] = opa[i];
      bus.req_b[i*32 +: 32] = opb[i];
      bus.req_valid[i] = 1'b1;
   endtask

   function automatic logic [3:0] oh(input int unsigned i);
      logic [3:0] r;
      r = '0;
      r[i] = 1'b1;
      return r;
   endfunction

   initial begin
      #100us;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      opa[0] = 32'h3F800000; opb[0] = 32'h3F800000; prd[0] = 32'h3F800000;
      opa[1] = 32'h40000000; opb[1] = 32'h40400000; prd[1] = 32'h40C00000;
      opa[2] = 32'h3FC00000; opb[2] = 32'h3FC00000; prd[2] = 32'h40100000;
      opa[3] = 32'h40000000; opb[3] = 32'h40000000; prd[3] = 32'h40800000;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.req_valid = '0;
      drain = 1'b0;

      // 1. Single op from requester 0: 2.0 * 3.0.
      do_reset();
      #1;
      check_eq("rst ready", bus.req_ready, 4'b0000);
      check_eq("rst rsp_valid", bus.rsp_valid, 4'b0000);
      check_eq("rst rsp_result", bus.rsp_result, 32'h0);
      check_eq("rst busy", busy, 1'b0);
      bus.req_a[31:0] = 32'h40000000;
      bus.req_b[31:0] = 32'h40400000;
      bus.req_valid[0] = 1'b1;
      #1;
      check_eq("t1 ready", bus.req_ready, 4'b0001);
      check_eq("t1 mul_a", bus.mul_a, 32'h40000000);
      check_eq("t1 mul_b", bus.mul_b, 32'h40400000);
      for (int c = 1; c <= 5; c++) begin
         next_cycle();
         bus.req_valid = '0;
         #1;
         if (c == 1) check_eq("t1 bubble mul_a", bus.mul_a, 32'h0);
         check_eq($sformatf("t1 rsp_valid c%0d", c), bus.rsp_valid, (c == 4) ? 4'b0001 : 4'b0000);
         check_eq($sformatf("t1 busy c%0d", c), busy, (c <= 4) ? 1'b1 : 1'b0);
         if (c >= 4) check_eq($sformatf("t1 rsp_result c%0d", c), bus.rsp_result, 32'h40C00000);
      end

      // 2. Fairness: all four valid continuously for eight grants.
      do_reset();
      for (int c = 0; c < 12; c++) begin
         if (c > 0) next_cycle();
         if (c == 0) for (int unsigned i = 0; i < NR; i++) put(i);
         if (c == 8) bus.req_valid = '0;
         #1;
         check_eq($sformatf("t2 ready c%0d", c), bus.req_ready,
                  (c < 8) ? oh(c % 4) : 4'b0000);
         check_eq($sformatf("t2 rsp_valid c%0d", c), bus.rsp_valid,
                  (c >= 4) ? oh((c - 4) % 4) : 4'b0000);
         if (c >= 4) check_eq($sformatf("t2 rsp_result c%0d", c), bus.rsp_result, prd[(c - 4) % 4]);
      end

      // 3. Outstanding limit on requester 1.
      do_reset();
      for (int c = 0; c < 10; c++) begin
         if (c > 0) next_cycle();
         if (c == 0) put(1);
         if (c == 6) bus.req_valid = '0;
         #1;
         if (c <= 5) check_eq($sformatf("t3 ready c%0d", c), bus.req_ready,
                              (c == 0 || c == 1 || c == 5) ? 4'b0010 : 4'b0000);
         check_eq($sformatf("t3 rsp_valid c%0d", c), bus.rsp_valid,
                  (c == 4 || c == 5 || c == 9) ? 4'b0010 : 4'b0000);
         if (c == 4) check_eq("t3 rsp_result", bus.rsp_result, prd[1]);
      end

      // 4. Routing: requester 2 then requester 3 in consecutive cycles.
      do_reset();
      for (int c = 0; c < 7; c++) begin
         if (c > 0) next_cycle();
         bus.req_valid = '0;
         if (c == 0) put(2);
         if (c == 1) put(3);
         #1;
         if (c == 0) check_eq("t4 ready2", bus.req_ready, 4'b0100);
         if (c == 1) check_eq("t4 ready3", bus.req_ready, 4'b1000);
         check_eq($sformatf("t4 rsp_valid c%0d", c), bus.rsp_valid,
                  (c == 4) ? 4'b0100 : (c == 5) ? 4'b1000 : 4'b0000);
         if (c == 4) check_eq("t4 rsp2", bus.rsp_result, 32'h40100000);
         if (c == 5) check_eq("t4 rsp3", bus.rsp_result, 32'h40800000);
      end

      // 5. Drain with two ops in flight.
      do_reset();
      for (int c = 0; c < 8; c++) begin
         if (c > 0) next_cycle();
         bus.req_valid = '0;
         if (c <= 2) put(c);
         if (c >= 3) put(2);
         drain = (c >= 2 && c <= 6);
         #1;
         if (c >= 2 && c <= 6) check_eq($sformatf("t5 ready drained c%0d", c), bus.req_ready, 4'b0000);
         if (c == 7) check_eq("t5 ready released", bus.req_ready, 4'b0100);
         if (c >= 3 && c <= 6)
            check_eq($sformatf("t5 rsp_valid c%0d", c), bus.rsp_valid,
                     (c == 4) ? 4'b0001 : (c == 5) ? 4'b0010 : 4'b0000);
         if (c == 5) check_eq("t5 busy last", busy, 1'b1);
         if (c == 6) check_eq("t5 busy idle", busy, 1'b0);
      end

      // 6. Reset with three ops in flight.
      do_reset();
      for (int c = 0; c < 10; c++) begin
         if (c > 0) next_cycle();
         bus.req_valid = '0;
         if (c <= 2) put(c);
         rst = (c == 3);
         if (c == 4) begin
            put(0);
            put(3);
         end
         #1;
         if (c == 4) begin
            check_eq("t6 ready after rst", bus.req_ready, 4'b0001);
            check_eq("t6 busy after rst", busy, 1'b0);
         end
         if (c >= 4)
            check_eq($sformatf("t6 rsp_valid c%0d", c), bus.rsp_valid,
                     (c == 8) ? 4'b0001 : 4'b0000);
         if (c == 8) check_eq("t6 rsp_result", bus.rsp_result, prd[0]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
